// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- BIST controller: FSM states, element
// indices and the per-element operation table.
package mbist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned ELEM_W = 3;

   localparam logic [ELEM_W-1:0] ELEM_E0 = 3'd0;
   localparam logic [ELEM_W-1:0] ELEM_E1 = 3'd1;
   localparam logic [ELEM_W-1:0] ELEM_E2 = 3'd2;
   localparam logic [ELEM_W-1:0] ELEM_E3 = 3'd3;
   localparam logic [ELEM_W-1:0] ELEM_E4 = 3'd4;
   localparam logic [ELEM_W-1:0] ELEM_E5 = 3'd5;

   typedef struct packed {
      logic       down;
      logic [1:0] num_ops;
      logic       has_rd;
      logic       rd_pol;
      logic       has_wr;
      logic       wr_pol;
   } march_elem_t;

   // Within an element the read (if any) always precedes the write.
   function automatic march_elem_t march_elem(input logic [ELEM_W-1:0] idx);
      march_elem_t e;
      case (idx)
         ELEM_E0: e = '{down: 1'b0, num_ops: 2'd1, has_rd: 1'b0, rd_pol: 1'b0, has_wr: 1'b1, wr_pol: 1'b0};
         ELEM_E1: e = '{down: 1'b0, num_ops: 2'd2, has_rd: 1'b1, rd_pol: 1'b0, has_wr: 1'b1, wr_pol: 1'b1};
         ELEM_E2: e = '{down: 1'b0, num_ops: 2'd2, has_rd: 1'b1, rd_pol: 1'b1, has_wr: 1'b1, wr_pol: 1'b0};
         ELEM_E3: e = '{down: 1'b1, num_ops: 2'd2, has_rd: 1'b1, rd_pol: 1'b0, has_wr: 1'b1, wr_pol: 1'b1};
         ELEM_E4: e = '{down: 1'b1, num_ops: 2'd2, has_rd: 1'b1, rd_pol: 1'b1, has_wr: 1'b1, wr_pol: 1'b0};
         ELEM_E5: e = '{down: 1'b0, num_ops: 2'd1, has_rd: 1'b1, rd_pol: 1'b0, has_wr: 1'b0, wr_pol: 1'b0};
         default: e = '0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Two-stage expected-data/address/element delay line aligned with the
// memory's read latency, plus comparator and first-failure capture.
module mbist_cmp_pipe
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  rd_valid,
   input  logic [DATA_WIDTH-1:0] rd_exp,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [ELEM_W-1:0]     rd_elem,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [ELEM_W-1:0]     fail_elem,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [7:0]            fail_count
);

   logic                  s1_vld, s2_vld;
   logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
   logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
   logic [ELEM_W-1:0]     s1_elem, s2_elem;
   logic                  mismatch;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_exp  <= '0;
         s1_addr <= '0;
         s1_elem <= '0;
         s2_vld  <= 1'b0;
         s2_exp  <= '0;
         s2_addr <= '0;
         s2_elem <= '0;
      end else begin
         s1_vld  <= rd_valid;
         s1_exp  <= rd_exp;
         s1_addr <= rd_addr;
         s1_elem <= rd_elem;
         s2_vld  <= s1_vld;
         s2_exp  <= s1_exp;
         s2_addr <= s1_addr;
         s2_elem <= s1_elem;
      end
   end

   always_comb begin
      mismatch = s2_vld && (rdata != s2_exp);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         fail       <= 1'b0;
         fail_addr  <= '0;
         fail_elem  <= '0;
         fail_data  <= '0;
         fail_count <= '0;
      end else if (mismatch) begin
         fail <= 1'b1;
         if (fail_count != 8'hFF) begin
            fail_count <= fail_count + 8'd1;
         end
         if (!fail) begin
            fail_addr <= s2_addr;
            fail_elem <= s2_elem;
            fail_data <= rdata;
         end
      end
   end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences E0..E5 one operation per cycle
// and hands every read to the compare pipeline.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int CAPACITY   = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [7:0]            fail_count,
   output logic                  write_read,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata
);

   localparam logic [ADDR_WIDTH-1:0] CAP_A = ADDR_WIDTH'(CAPACITY);
   localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

   state_t              state, state_n;
   logic [ELEM_W-1:0]   elem, elem_n;
   logic [ADDR_WIDTH-1:0] idx, idx_n;
   logic                op, op_n;
   logic                drain, drain_n;
   march_elem_t         el;
   logic                run, last_op, last_idx, is_rd, is_wr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         elem  <= '0;
         idx   <= '0;
         op    <= 1'b0;
         drain <= 1'b0;
      end else begin
         state <= state_n;
         elem  <= elem_n;
         idx   <= idx_n;
         op    <= op_n;
         drain <= drain_n;
      end
   end

   always_comb begin
      el       = march_elem(elem);
      run      = (state == RUN);
      last_op  = ({1'b0, op} == (el.num_ops - 2'd1));
      last_idx = (idx == CAP_A);
      is_rd    = el.has_rd && !op;
      is_wr    = el.has_wr && !is_rd;

      state_n = state;
      elem_n  = elem;
      idx_n   = idx;
      op_n    = op;
      drain_n = drain;

      case (state)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               elem_n  = ELEM_E0;
               idx_n   = '0;
               op_n    = 1'b0;
            end
         end
         RUN: begin
            if (!last_op) begin
               op_n = 1'b1;
            end else begin
               op_n = 1'b0;
               if (!last_idx) begin
                  idx_n = idx + ONE_A;
               end else begin
                  idx_n = '0;
                  if (elem == ELEM_E5) begin
                     state_n = DRAIN;
                     elem_n  = ELEM_E0;
                     drain_n = 1'b0;
                  end else begin
                     elem_n = elem + 3'd1;
                  end
               end
            end
         end
         DRAIN: begin
            if (drain) begin
               state_n = DONE;
            end else begin
               drain_n = 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // idx always counts up; down elements mirror it onto the address.
   assign address    = el.down ? (CAP_A - idx) : idx;
   assign write_read = run && is_wr;
   assign busy       = (state == RUN) || (state == DRAIN);
   assign done       = (state == DONE);

   // Every element after E0 opens with a read, so the current element's write
   // polarity is always the data of the next write one cycle early.
   assign wdata = run ? {DATA_WIDTH{el.wr_pol}} : '0;

   mbist_cmp_pipe #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_cmp (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     ((state == IDLE) && start),
      .rd_valid  (run && is_rd),
      .rd_exp    ({DATA_WIDTH{el.rd_pol}}),
      .rd_addr   (address),
      .rd_elem   (elem),
      .rdata     (rdata),
      .fail      (fail),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .fail_data (fail_data),
      .fail_count(fail_count)
   );

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: memory address width.
REQ-003 SHALL have parameter CAPACITY, default 15: highest tested address; the tested range is 0..CAPACITY.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: level-sampled request to begin a test.
REQ-007 SHALL have port busy, output, 1 bit: a test is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse at test end.
REQ-009 SHALL have port fail, output, 1 bit: sticky flag, set when any mismatch occurs in the current or last test.
REQ-010 SHALL have port fail_addr, output, ADDR_WIDTH bits: address of the first mismatch.
REQ-011 SHALL have port fail_elem, output, 3 bits: March element index (0..5) of the first mismatch.
REQ-012 SHALL have port fail_data, output, DATA_WIDTH bits: read data at the first mismatch.
REQ-013 SHALL have port fail_count, output, 8 bits: mismatch count, saturating at 255.
REQ-014 SHALL have port write_read, output, 1 bit: memory command, 1=write, 0=read.
REQ-015 SHALL have port address, output, ADDR_WIDTH bits: memory address.
REQ-016 SHALL have port wdata, output, DATA_WIDTH bits: memory write data.
REQ-017 SHALL have port rdata, input, DATA_WIDTH bits: memory read data.

Function
REQ-018 SHALL execute March C- with word backgrounds Z=all-0 and O=all-1, one memory operation per cycle:
- E0: up w0
- E1: up (r0,w1)
- E2: up (r1,w0)
- E3: down (r0,w1)
- E4: down (r1,w0)
- E5: up r0
REQ-019 SHALL traverse "up" elements from 0 to CAPACITY and "down" elements from CAPACITY to 0, with no gaps between elements.
REQ-020 SHALL drive wdata one cycle before the cycle in which the matching write command is issued, because the memory registers write data one cycle ahead of use.
REQ-021 SHALL treat memory read latency as 2 cycles: a read issued in cycle t returns valid rdata, to be compared, in cycle t+2.
REQ-022 SHALL carry expected data, address and element index for each read through a 2-stage pipeline, aligned with rdata.
REQ-023 SHALL use the following FSM states and transitions:
- IDLE -> RUN on start=1.
- RUN -> DRAIN after the last E5 read.
- DRAIN is held for 2 cycles for the outstanding compares.
- DRAIN -> DONE.
- DONE -> IDLE after one cycle.
REQ-024 SHALL assert busy in RUN and DRAIN, and assert done only in DONE.
REQ-025 SHALL ignore start while busy, and SHALL start a new test if start is held high in IDLE.
REQ-026 SHALL, on entry to RUN, clear fail, fail_count, fail_addr, fail_elem and fail_data.
REQ-027 SHALL, on a mismatch, set fail and increment fail_count, saturating at 255.
REQ-028 SHALL capture fail_addr, fail_elem and fail_data only on the first mismatch of a test.
REQ-029 SHALL hold write_read=0 outside RUN, and all failure outputs SHALL hold their values until the next start.
REQ-030 SHALL take exactly 10*(CAPACITY+1) RUN cycles.

Reset
REQ-031 SHALL, while rst_n=0 at a rising clk edge, go to IDLE and clear every output to 0, including address, wdata, write_read and the compare pipeline.
REQ-032 SHALL abort a test in progress when reset occurs mid-test, with no done pulse and no trailing compares after release.

Structure
REQ-033 SHALL place the FSM state encoding, element-index constants and March element table (direction, op count, read/write polarity) in shared package mbist_pkg.
REQ-034 SHALL split out one sub-module, mbist_cmp_pipe, holding the 2-stage expected/address/element delay line plus comparator and failure capture.
REQ-035 SHALL keep the RTL at 120-400 lines total.

Verification
Each scenario below uses DATA_WIDTH=8, ADDR_WIDTH=4, CAPACITY=15, with a behavioural 2-cycle-latency memory model.
REQ-036 SHALL verify fault-free memory: one start pulse -> busy for 162 cycles, done pulses once, fail=0, fail_count=0.
REQ-037 SHALL verify a bit-0 stuck-at-1 fault at address 5 -> fail=1, fail_elem=1, fail_addr=5, fail_data=8'h01, fail_count=3.
REQ-038 SHALL verify a coupling fault where a write of 1 to address 6 flips address 7 -> first failure at fail_elem=1, fail_addr=7.
REQ-039 SHALL verify reset: rst_n=0 for 1 cycle at RUN cycle 50 -> IDLE next cycle, all outputs 0, no done pulse; a subsequent start runs a full 162-cycle test.
REQ-040 SHALL verify start handling: start held high throughout -> back-to-back tests, each separated by one DONE cycle and one IDLE cycle, with failure outputs cleared at each new RUN entry.
REQ-041 SHALL verify address and wdata ordering: the first E3 operation reads address 15, and wdata=8'hFF is presented one cycle before each E1/E3 write.
